// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with oversampled start/data/stop detection feeding a small byte FIFO.
// Latency: rx edge seen 2 clk later (synchroniser); a good byte is readable the cycle after its stop-sample tick.
// Backpressure: rd_valid/rd_ready pop interface; a good byte arriving while full is dropped and flags overrun.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   tick       one-cycle enable at OVERSAMPLE x baud
//   rx         asynchronous serial input, idles high
//   rd_data    byte at FIFO head (meaningful only while rd_valid)
//   rd_valid   FIFO not empty
//   rd_ready   consumer accepts rd_data; pop on rd_valid && rd_ready
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: good byte arrived while FIFO full
//   clr_err    one-cycle pulse clearing both sticky flags (a simultaneous set wins)

module uart_rx_fifo #(
   parameter int OVERSAMPLE = 16,
   parameter int DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       rx,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       clr_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_e;

   // ------------------------------------------------------------------
   // Input synchroniser (resets to the idle-high level so a reset never
   // looks like a start edge)
   // ------------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;
   logic rx_s;

   assign rx_s = sync2_q;

   // ------------------------------------------------------------------
   // Receive FSM state
   // ------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bidx_q, bidx_d;
   logic [7:0]      shreg_q, shreg_d;

   logic            push;
   logic            set_ferr;
   logic            set_ovr;

   // ------------------------------------------------------------------
   // FIFO state
   // ------------------------------------------------------------------
   logic [7:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;

   logic            pop;
   logic            fifo_full;

   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;

   assign rd_valid  = (count_q != '0);
   assign rd_data   = mem[rd_ptr_q];
   assign pop       = rd_valid && rd_ready;
   assign fifo_full = (count_q == CNT_FULL);

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   // ------------------------------------------------------------------
   // FSM next-state logic; everything advances only on tick
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bidx_d   = bidx_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      set_ferr = 1'b0;
      set_ovr  = 1'b0;

      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end
            end

            S_START: begin
               if (cnt_q == CNT_MID) begin
                  cnt_d = '0;
                  if (!rx_s) begin
                     state_d = S_DATA;
                     bidx_d  = 3'd0;
                  end else begin
                     // Start bit did not survive to mid-bit: treat as noise.
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            S_DATA: begin
               if (cnt_q == CNT_END) begin
                  // LSB-first line order: shift in at the MSB so bit 0 ends at the LSB.
                  shreg_d = {rx_s, shreg_q[7:1]};
                  cnt_d   = '0;
                  bidx_d  = bidx_q + 3'd1;
                  if (bidx_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            S_STOP: begin
               if (cnt_q == CNT_END) begin
                  cnt_d = '0;
                  if (rx_s) begin
                     state_d = S_IDLE;
                     // A same-cycle pop frees the slot even when full.
                     if (!fifo_full || pop) begin
                        push = 1'b1;
                     end else begin
                        set_ovr = 1'b1;
                     end
                  end else begin
                     state_d  = S_WAIT_HIGH;
                     set_ferr = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            S_WAIT_HIGH: begin
               // Hold off until the line returns high so a break cannot
               // immediately re-trigger a start.
               if (rx_s) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FIFO pointer / occupancy logic
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (PW + 1)'(1);
         2'b01:   count_d = count_q - (PW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // ------------------------------------------------------------------
   // Sticky flags: set has priority over clear
   // ------------------------------------------------------------------
   always_comb begin
      frame_err_d = set_ferr | (frame_err_q & ~clr_err);
      overrun_d   = set_ovr  | (overrun_q   & ~clr_err);
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bidx_q      <= 3'd0;
         shreg_q     <= 8'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= rx;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bidx_q      <= bidx_d;
         shreg_q     <= shreg_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Storage needs no reset: entries are only observable once written.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem[wr_ptr_q] <= shreg_q;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed 8N1 frames, expected bytes queued at issue time,
// a separate monitor compares every popped byte; flag/valid checks done inline.
// Tick runs at 1 per 4 clk, so one bit period is 64 clk.

module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       rx;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       frame_err;
   logic       overrun;
   logic       clr_err;

   int         n_vec = 0;
   int         n_err = 0;
   int         tphase = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.OVERSAMPLE(16), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .rx        (rx),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .clr_err   (clr_err)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge; tick is generated here so it can never
   // race with other stimulus.
   task automatic cyc();
      @(negedge clk);
      tphase = (tphase + 1) % 4;
      tick   = (tphase == 0);
   endtask

   // Returns at the falling edge just after the n-th tick has been clocked.
   task automatic wait_ticks(input int n);
      repeat (n) begin
         do cyc(); while (!tick);
         cyc();
      end
   endtask

   task automatic pop_n(input int n);
      rd_ready = 1'b1;
      repeat (n) cyc();
      rd_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
   endtask

   // mode 0: normal stop bit
   // mode 1: normal stop, check rd_valid rises exactly one cycle after the stop-sample tick
   // mode 2: normal stop, rd_ready asserted only on the stop-sample cycle
   // mode 3: stop held low for 2 bit times, then high
   // Start is detected at tick 1 after the fall, so the stop sample is the 9th tick of the stop bit.
   task automatic send_byte(input logic [7:0] d, input int mode);
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_ticks(16);
      end
      case (mode)
         1: begin
            rx = 1'b1;
            wait_ticks(8);
            while (!tick) cyc();
            check("valid_before_stop_tick", {7'd0, rd_valid}, 8'd0);
            cyc();
            check("valid_after_stop_tick", {7'd0, rd_valid}, 8'd1);
            wait_ticks(7);
         end
         2: begin
            rx = 1'b1;
            wait_ticks(8);
            while (!tick) cyc();
            rd_ready = 1'b1;
            cyc();
            rd_ready = 1'b0;
            wait_ticks(7);
         end
         3: begin
            rx = 1'b0;
            wait_ticks(32);
            rx = 1'b1;
            wait_ticks(16);
         end
         default: begin
            rx = 1'b1;
            wait_ticks(16);
         end
      endcase
   endtask

   // Scoreboard monitor: every accepted pop is matched against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pop: got 0x%0h, expected no data", rd_data);
            end else begin
               check("pop_data", rd_data, exp_q.pop_front());
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      tick     = 1'b0;
      rx       = 1'b1;
      rd_ready = 1'b0;
      clr_err  = 1'b0;
      repeat (4) cyc();
      rst = 1'b1;
      cyc();

      // Reset state
      check("reset_valid",     {7'd0, rd_valid},  8'd0);
      check("reset_frame_err", {7'd0, frame_err}, 8'd0);
      check("reset_overrun",   {7'd0, overrun},   8'd0);

      // 0x55 with exact push latency
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1);
      check("t1_frame_err", {7'd0, frame_err}, 8'd0);
      check("t1_overrun",   {7'd0, overrun},   8'd0);
      pop_n(1);
      check("t1_valid_after_pop", {7'd0, rd_valid}, 8'd0);

      // Glitch start, then a real frame
      rx = 1'b0;
      wait_ticks(4);
      rx = 1'b1;
      wait_ticks(20);
      check("t2_glitch_no_push", {7'd0, rd_valid}, 8'd0);
      exp_q.push_back(8'hA3);
      send_byte(8'hA3, 0);
      check("t2_valid", {7'd0, rd_valid}, 8'd1);
      pop_n(1);
      check("t2_valid_after_pop", {7'd0, rd_valid}, 8'd0);

      // Framing error, then a good byte, then clear
      send_byte(8'h3C, 3);
      check("t3_frame_err_set", {7'd0, frame_err}, 8'd1);
      check("t3_no_push",       {7'd0, rd_valid},  8'd0);
      exp_q.push_back(8'h12);
      send_byte(8'h12, 0);
      check("t3_valid",         {7'd0, rd_valid},  8'd1);
      check("t3_frame_err_kept",{7'd0, frame_err}, 8'd1);
      pop_n(1);
      pulse_clr();
      check("t3_frame_err_clr", {7'd0, frame_err}, 8'd0);

      // Overrun: 5 bytes into a 4-deep FIFO
      for (int b = 1; b <= 5; b++) begin
         if (b <= 4) exp_q.push_back(8'(b));
         send_byte(8'(b), 0);
      end
      check("t4_overrun_set", {7'd0, overrun},   8'd1);
      check("t4_no_ferr",     {7'd0, frame_err}, 8'd0);
      pop_n(4);
      check("t4_empty", {7'd0, rd_valid}, 8'd0);
      pulse_clr();
      check("t4_overrun_clr", {7'd0, overrun}, 8'd0);

      // Full FIFO with a pop on the stop-sample cycle
      for (int b = 1; b <= 4; b++) begin
         exp_q.push_back(8'(b * 16));
         send_byte(8'(b * 16), 0);
      end
      check("t5_full_no_ovr", {7'd0, overrun}, 8'd0);
      exp_q.push_back(8'h77);
      send_byte(8'h77, 2);
      check("t5_overrun", {7'd0, overrun},  8'd0);
      check("t5_valid",   {7'd0, rd_valid}, 8'd1);
      pop_n(4);
      check("t5_empty", {7'd0, rd_valid}, 8'd0);

      // Reset mid-frame with buffered bytes and a flag set
      exp_q.push_back(8'hAA);
      send_byte(8'hAA, 0);
      exp_q.push_back(8'hBB);
      send_byte(8'hBB, 0);
      send_byte(8'h3C, 3);
      check("t6_valid_before", {7'd0, rd_valid},  8'd1);
      check("t6_ferr_before",  {7'd0, frame_err}, 8'd1);
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx = (8'hE7 >> i) & 8'h01;
         wait_ticks(16);
      end
      rx = 1'b1;
      wait_ticks(5);
      rst = 1'b0;
      repeat (3) cyc();
      rst = 1'b1;
      exp_q.delete();
      cyc();
      check("t6_valid_after", {7'd0, rd_valid},  8'd0);
      check("t6_ferr_after",  {7'd0, frame_err}, 8'd0);
      check("t6_ovr_after",   {7'd0, overrun},   8'd0);
      wait_ticks(5);
      exp_q.push_back(8'hC9);
      send_byte(8'hC9, 0);
      check("t6_valid_new", {7'd0, rd_valid}, 8'd1);
      pop_n(1);
      check("t6_empty", {7'd0, rd_valid}, 8'd0);

      repeat (4) cyc();
      check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
